// File: rtl/fifo_rd_fwft.sv
// ---------------------------------------------------------------------------
// fifo_rd_fwft
//   Read-side output stage of the async FIFO. Turns the pop interface of the
//   read-pointer block and RAM read port (rinc / rempty / rdata) into a
//   first-word-fall-through valid/ready stream in the rclk domain.
//
//   A small in-order output buffer of RD_LAT+2 entries absorbs the RAM read
//   latency, so the stream sustains one word per cycle. Pops are issued only
//   while the buffer plus the words still in flight from the RAM has room.
//   Because of that, a stalled consumer never causes an overflow.
//   m_ready feeds only registered state and never reaches rinc
//   combinationally.
//
// Parameters
//   DSIZE   data word width
//   RD_LAT  RAM read latency in rclk cycles: 0 = combinational read,
//           1 = registered read. Any non-zero value is treated as 1.
//
// Ports
//   rclk      in   read-domain clock
//   rrst_n    in   synchronous active-low reset
//   rempty    in   registered FIFO empty flag
//   rdata     in   RAM read data, valid RD_LAT cycles after a pop
//   rinc      out  pop request to the read-pointer block
//   m_valid   out  output word valid
//   m_data    out  output word (oldest buffered entry)
//   m_ready   in   consumer accepts m_data when m_valid & m_ready
//   ob_level  out  words held in the output buffer (0..RD_LAT+2)
// ---------------------------------------------------------------------------
module fifo_rd_fwft #(
  parameter int DSIZE  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic [1:0]       ob_level
);

  localparam int OB_DEPTH = (RD_LAT == 0) ? 2 : 3;

  // Registered state
  logic [1:0]       r_level;
  logic             r_valid;
  logic [DSIZE-1:0] r_buf [OB_DEPTH];

  // Combinational helpers
  logic [1:0]       w_inflight;
  logic [2:0]       w_occ;
  logic             w_issue;
  logic             w_cap;
  logic [DSIZE-1:0] w_cap_data;
  logic             w_pop;
  logic [1:0]       w_widx;
  logic [1:0]       w_level_nxt;
  logic [DSIZE-1:0] w_buf_nxt [OB_DEPTH];

  // The buffer and in-flight pops together reserve a slot for every word.
  // A pop is therefore issued only when a slot is free.
  // Every term here is registered, so rinc has no path from m_ready.
  assign w_occ   = {1'b0, r_level} + {1'b0, w_inflight};
  assign w_issue = rrst_n & ~rempty & (w_occ < 3'(OB_DEPTH));
  assign rinc    = w_issue;

  generate
    if (RD_LAT == 0) begin : gen_lat0
      // Combinational RAM: the word is captured on the edge that takes the pop.
      assign w_inflight = 2'b00;
      assign w_cap      = w_issue;
      assign w_cap_data = rdata;
    end else begin : gen_lat1
      logic r_pend;

      // Remembers a pop issued last cycle; its data arrives on rdata this cycle.
      // Reset clears it, so late rdata after a reset is never captured.
      always_ff @(posedge rclk) begin
        if (!rrst_n) begin
          r_pend <= 1'b0;
        end else begin
          r_pend <= w_issue;
        end
      end

      assign w_inflight = {1'b0, r_pend};
      assign w_cap      = r_pend;
      assign w_cap_data = rdata;
    end
  endgenerate

  // Shift-register buffer next state: entry 0 is always the head.
  // A pop shifts everything down one place.
  // A capture lands just above the last valid entry after the shift.
  // That keeps order when a capture and a pop happen together.
  always_comb begin
    w_pop       = r_valid & m_ready;
    w_widx      = r_level - {1'b0, w_pop};
    w_level_nxt = r_level + {1'b0, w_cap} - {1'b0, w_pop};
    for (int i = 0; i < OB_DEPTH; i++) begin
      w_buf_nxt[i] = r_buf[i];
    end
    if (w_pop) begin
      for (int i = 0; i < OB_DEPTH - 1; i++) begin
        w_buf_nxt[i] = r_buf[i + 1];
      end
    end else begin
      for (int i = 0; i < OB_DEPTH; i++) begin
        w_buf_nxt[i] = r_buf[i];
      end
    end
    for (int i = 0; i < OB_DEPTH; i++) begin
      w_buf_nxt[i] = (w_cap && (w_widx == 2'(i))) ? w_cap_data : w_buf_nxt[i];
    end
  end

  // Buffer, level and valid registers. m_valid is registered from the next level.
  // A capture into an empty buffer therefore shows m_valid on the following cycle.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_level <= 2'd0;
      r_valid <= 1'b0;
      for (int i = 0; i < OB_DEPTH; i++) begin
        r_buf[i] <= {DSIZE{1'b0}};
      end
    end else begin
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != 2'd0);
      for (int i = 0; i < OB_DEPTH; i++) begin
        r_buf[i] <= w_buf_nxt[i];
      end
    end
  end

  assign m_valid  = r_valid;
  assign m_data   = r_buf[0];
  assign ob_level = r_level;

  fifo_rd_fwft_chk #(
    .OB_DEPTH (OB_DEPTH)
  ) u_chk (
    .i_clk      (rclk),
    .i_rst_n    (rrst_n),
    .i_rempty   (rempty),
    .i_rinc     (rinc),
    .i_level    (r_level),
    .i_inflight (w_inflight),
    .i_valid    (r_valid)
  );

endmodule

// ---------------------------------------------------------------------------
// fifo_rd_fwft_chk
//   Property checker for the read-side output stage.
//   It contains no logic that reaches silicon.
//   Ports: clock, reset, rempty/rinc pop handshake, buffer level, in-flight
//   count and m_valid.
// ---------------------------------------------------------------------------
module fifo_rd_fwft_chk #(
  parameter int OB_DEPTH = 3
) (
  input logic       i_clk,
  input logic       i_rst_n,
  input logic       i_rempty,
  input logic       i_rinc,
  input logic [1:0] i_level,
  input logic [1:0] i_inflight,
  input logic       i_valid
);

  a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    ({1'b0, i_level} + {1'b0, i_inflight}) <= 3'(OB_DEPTH));

  a_no_pop_empty : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_rinc |-> !i_rempty);

  a_valid_level : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_valid == (i_level != 2'd0));

endmodule

// File: tb/tb_fifo_rd_fwft.sv
module tb_fifo_rd_fwft;

  logic rclk = 1'b0;
  logic rrst_n;
  always #5 rclk = ~rclk;

  // DUT a: RD_LAT=0, DUT b: RD_LAT=1
  logic       rempty_a, rinc_a, m_valid_a, m_ready_a;
  logic [7:0] rdata_a, m_data_a;
  logic [1:0] ob_level_a;
  logic       rempty_b, rinc_b, m_valid_b, m_ready_b;
  logic [7:0] rdata_b, m_data_b;
  logic [1:0] ob_level_b;

  fifo_rd_fwft #(.DSIZE(8), .RD_LAT(0)) u_dut_a (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty_a), .rdata(rdata_a),
    .rinc(rinc_a), .m_valid(m_valid_a), .m_data(m_data_a),
    .m_ready(m_ready_a), .ob_level(ob_level_a));

  fifo_rd_fwft #(.DSIZE(8), .RD_LAT(1)) u_dut_b (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty_b), .rdata(rdata_b),
    .rinc(rinc_b), .m_valid(m_valid_b), .m_data(m_data_b),
    .m_ready(m_ready_b), .ob_level(ob_level_b));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Upstream FIFO models: word store, write/read indices, scoreboards.
  logic [7:0] mem_a [4096];
  logic [7:0] mem_b [4096];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];

  assign rempty_a = (rd_a == wr_a);
  assign rempty_b = (rd_b == wr_b);
  assign rdata_a  = mem_a[rd_a & 4095];

  always @(posedge rclk) begin
    if (!rrst_n) begin
      rd_a <= wr_a;
    end else if (rinc_a) begin
      check("rinc_a_nonempty", rempty_a, 0);
      rd_a <= rd_a + 1;
    end
  end

  // Registered RAM for b: rdata is not cleared by reset (late-data case).
  always @(posedge rclk) begin
    if (!rrst_n) begin
      rd_b <= wr_b;
    end else if (rinc_b) begin
      check("rinc_b_nonempty", rempty_b, 0);
      rdata_b <= mem_b[rd_b & 4095];
      rd_b    <= rd_b + 1;
    end
  end

  task automatic push_word(input int d, input logic [7:0] v);
    if (d == 0) begin
      mem_a[wr_a & 4095] = v; wr_a++; exp_a.push_back(v);
    end else begin
      mem_b[wr_b & 4095] = v; wr_b++; exp_b.push_back(v);
    end
  endtask

  // Output monitors: scoreboard on every handshake, stability on every stall.
  logic stall_a = 1'b0, stall_b = 1'b0;
  logic [7:0] hold_a, hold_b;

  always @(negedge rclk) begin
    if (!rrst_n) begin
      stall_a <= 1'b0;
      stall_b <= 1'b0;
    end else begin
      if (m_valid_a && m_ready_a) begin
        if (exp_a.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_a: got %h expected nothing (scoreboard empty)", m_data_a);
        end else check("sb_a_data", m_data_a, exp_a.pop_front());
      end
      if (m_valid_b && m_ready_b) begin
        if (exp_b.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_b: got %h expected nothing (scoreboard empty)", m_data_b);
        end else check("sb_b_data", m_data_b, exp_b.pop_front());
      end
      if (stall_a) begin
        check("stall_a_valid", m_valid_a, 1);
        check("stall_a_data", m_data_a, hold_a);
      end
      if (stall_b) begin
        check("stall_b_valid", m_valid_b, 1);
        check("stall_b_data", m_data_b, hold_b);
      end
      stall_a <= m_valid_a & ~m_ready_a;
      stall_b <= m_valid_b & ~m_ready_b;
      hold_a  <= m_data_a;
      hold_b  <= m_data_b;
    end
  end

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  typedef struct {
    int         nwr;
    logic [7:0] wbase;
    logic       rdy;
    logic       e_rinc;
    logic       e_valid;
    logic [7:0] e_data;
    logic [1:0] e_lvl;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wa, wb;
    // Test 2 (RD_LAT=1 stream of 5 words), then test 3 (stall with 10 words)
    tbl[0]  = '{5,  8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[1]  = '{0,  8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[2]  = '{0,  8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 2'd1};
    tbl[3]  = '{0,  8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 2'd1};
    tbl[4]  = '{0,  8'h00, 1'b1, 1'b1, 1'b1, 8'h13, 2'd1};
    tbl[5]  = '{0,  8'h00, 1'b1, 1'b0, 1'b1, 8'h14, 2'd1};
    tbl[6]  = '{0,  8'h00, 1'b1, 1'b0, 1'b1, 8'h15, 2'd1};
    tbl[7]  = '{0,  8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
    tbl[8]  = '{10, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[9]  = '{0,  8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[10] = '{0,  8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 2'd1};
    tbl[11] = '{0,  8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 2'd2};
    tbl[12] = '{0,  8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 2'd3};
    tbl[13] = '{0,  8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 2'd3};
    tbl[14] = '{0,  8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 2'd3};
    tbl[15] = '{0,  8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 2'd2};
    tbl[16] = '{0,  8'h00, 1'b1, 1'b1, 1'b1, 8'h13, 2'd1};

    // Test 1: reset with both sources empty
    rrst_n = 1'b0; m_ready_a = 1'b0; m_ready_b = 1'b0;
    repeat (4) step();
    @(negedge rclk);
    check("rst_valid_a", m_valid_a, 0);   check("rst_valid_b", m_valid_b, 0);
    check("rst_rinc_a", rinc_a, 0);       check("rst_rinc_b", rinc_b, 0);
    check("rst_lvl_a", ob_level_a, 0);    check("rst_lvl_b", ob_level_b, 0);
    check("rst_data_a", m_data_a, 0);     check("rst_data_b", m_data_b, 0);
    step();
    rrst_n = 1'b1;

    // Tests 2 and 3 on the registered-read instance
    for (int i = 0; i < 17; i++) begin
      step();
      m_ready_b = tbl[i].rdy;
      for (int j = 0; j < tbl[i].nwr; j++) push_word(1, tbl[i].wbase + 8'(j));
      @(negedge rclk);
      check($sformatf("tbl%0d_rinc", i), rinc_b, tbl[i].e_rinc);
      check($sformatf("tbl%0d_valid", i), m_valid_b, tbl[i].e_valid);
      check($sformatf("tbl%0d_lvl", i), ob_level_b, tbl[i].e_lvl);
      if (tbl[i].e_valid) check($sformatf("tbl%0d_data", i), m_data_b, tbl[i].e_data);
    end
    for (int k = 0; k < 50 && exp_b.size() != 0; k++) step();
    check("stall_drain_b", exp_b.size(), 0);
    step();

    // Test 4: combinational-read instance, single word then a stream
    m_ready_a = 1'b1;
    step();
    push_word(0, 8'hA5);
    @(negedge rclk);
    check("a5_rinc", rinc_a, 1);
    check("a5_valid_early", m_valid_a, 0);
    step();
    @(negedge rclk);
    check("a5_valid", m_valid_a, 1);
    check("a5_data", m_data_a, 8'hA5);
    check("a5_lvl", ob_level_a, 1);
    step();
    @(negedge rclk);
    check("a5_gone", m_valid_a, 0);
    step();
    for (int j = 0; j < 8; j++) push_word(0, 8'h30 + 8'(j));
    @(negedge rclk);
    check("strm_rinc", rinc_a, 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      @(negedge rclk);
      check($sformatf("strm_valid%0d", k), m_valid_a, 1);
      check($sformatf("strm_lvl%0d", k), (ob_level_a <= 2'd2), 1);
    end
    step();
    @(negedge rclk);
    check("strm_end", m_valid_a, 0);

    // Test 5: reset while ob_level=2 and one pop is in flight
    m_ready_a = 1'b0; m_ready_b = 1'b0;
    step();
    for (int j = 0; j < 5; j++) push_word(1, 8'h51 + 8'(j));
    step(); step(); step();
    rrst_n = 1'b0;
    @(negedge rclk);
    check("mid_rst_lvl_before", ob_level_b, 2);
    check("mid_rst_rinc", rinc_b, 0);
    step();
    rrst_n = 1'b1;
    exp_a.delete();
    exp_b.delete();
    @(negedge rclk);
    check("mid_rst_valid", m_valid_b, 0);
    check("mid_rst_lvl", ob_level_b, 0);
    check("mid_rst_data", m_data_b, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge rclk);
      check($sformatf("no_stale%0d", k), m_valid_b, 0);
    end
    m_ready_b = 1'b1;
    step();
    push_word(1, 8'h77);
    step();
    step();
    @(negedge rclk);
    check("post_rst_valid", m_valid_b, 1);
    check("post_rst_data", m_data_b, 8'h77);
    step();

    // Test 6: random writes and random ready on both instances
    wa = 0; wb = 0;
    for (int k = 0; k < 10000 && (wa < 1000 || wb < 1000); k++) begin
      step();
      m_ready_a = 1'($urandom_range(0, 1));
      m_ready_b = 1'($urandom_range(0, 1));
      if (wa < 1000 && $urandom_range(0, 1) == 1) begin
        push_word(0, 8'($urandom)); wa++;
      end
      if (wb < 1000 && $urandom_range(0, 1) == 1) begin
        push_word(1, 8'($urandom)); wb++;
      end
    end
    step();
    m_ready_a = 1'b1; m_ready_b = 1'b1;
    for (int k = 0; k < 200 && (exp_a.size() != 0 || exp_b.size() != 0); k++) step();
    check("rand_count_a", wa, 1000);
    check("rand_count_b", wb, 1000);
    check("rand_drain_a", exp_a.size(), 0);
    check("rand_drain_b", exp_b.size(), 0);
    step();
    @(negedge rclk);
    check("rand_idle_a", m_valid_a, 0);
    check("rand_idle_b", m_valid_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
